vid_frame_ctrl: RTL and testbench

VID_FRAME_CTRL -- requirements
Module: vid_frame_ctrl

---
 rtl/vid_stream_pkg.sv | 15 +
 rtl/vid_pos_counter.sv | 59 +++++
 rtl/vid_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vid_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_stream_pkg.sv
// Shared types and constants for the video frame controller slice.
package vid_stream_pkg;

    localparam int unsigned TDATA_W     = 96;
    localparam int unsigned PPC         = 4;
    localparam int unsigned DEF_H_BEATS = 16;
    localparam int unsigned DEF_V_LINES = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_PASS     = 2'd2
    } vid_state_e;

endpackage

// File: rtl/vid_pos_counter.sv
// Beat/line position tracker for one video frame; flags line and frame ends.
// VID_FRAME_CTRL_ERR_EN adds the early/late end-of-line flags.
module vid_pos_counter
    import vid_stream_pkg::*;
#(
    parameter int unsigned H_BEATS = DEF_H_BEATS,
    parameter int unsigned V_LINES = DEF_V_LINES,
    parameter int unsigned CNT_W   = 12
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_beat,
    input  logic i_sof,
    input  logic i_eol,
`ifdef VID_FRAME_CTRL_ERR_EN
    output logic o_eol_early,
    output logic o_eol_late,
`endif
    output logic o_frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_BEATS - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_LINES - 1);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_line_end;

    assign w_h_last   = (r_hcnt == H_LAST);
    assign w_v_last   = (r_vcnt == V_LAST);
    // An SOF beat always restarts the frame, so it never counts as a line end.
    assign w_line_end = i_beat & ~i_sof & i_eol;
    assign o_frame_end = w_line_end & w_v_last;

`ifdef VID_FRAME_CTRL_ERR_EN
    assign o_eol_early = w_line_end & (r_hcnt < H_LAST);
    assign o_eol_late  = i_beat & ~i_sof & ~i_eol & w_h_last;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_beat) begin
            if (i_sof) begin
                r_hcnt <= CNT_W'(1);
                r_vcnt <= '0;
            end else if (i_eol) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
            end else if (!w_h_last) begin
                r_hcnt <= r_hcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vid_frame_ctrl.sv
// Start/stop frame gate for an AXI4-Stream video link with frame counting.
// Define VID_FRAME_CTRL_ERR_EN to enable the sticky framing error flags.
module vid_frame_ctrl
    import vid_stream_pkg::*;
#(
    parameter int unsigned H_BEATS = DEF_H_BEATS,
    parameter int unsigned V_LINES = DEF_V_LINES,
    parameter int unsigned CNT_W   = 12
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [TDATA_W-1:0] s_axis_video_tdata,
    input  logic               s_axis_video_tvalid,
    output logic               s_axis_video_tready,
    input  logic               s_axis_video_tuser,
    input  logic               s_axis_video_tlast,
    output logic [TDATA_W-1:0] m_axis_video_tdata,
    output logic               m_axis_video_tvalid,
    input  logic               m_axis_video_tready,
    output logic               m_axis_video_tuser,
    output logic               m_axis_video_tlast,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_count,
    output logic               err_eol_early,
    output logic               err_eol_late,
    output logic               err_sof
);

    vid_state_e       r_state;
    logic             r_stop_pending;
    logic [CNT_W-1:0] r_frame_count;
    logic             w_pass_en;
    logic             w_beat;
    logic             w_sof;
    logic             w_frame_end;
    logic             w_start_acc;

    // The SOF beat itself passes while still waiting, giving zero-latency capture.
    assign w_pass_en = (r_state == ST_PASS) |
                       ((r_state == ST_WAIT_SOF) & s_axis_video_tuser);

    assign m_axis_video_tdata  = s_axis_video_tdata;
    assign m_axis_video_tuser  = s_axis_video_tuser;
    assign m_axis_video_tlast  = s_axis_video_tlast;
    assign m_axis_video_tvalid = w_pass_en & s_axis_video_tvalid;
    assign s_axis_video_tready = w_pass_en ? m_axis_video_tready : 1'b1;

    assign w_beat      = w_pass_en & s_axis_video_tvalid & m_axis_video_tready;
    assign w_sof       = w_beat & s_axis_video_tuser;
    assign w_start_acc = (r_state == ST_IDLE) & start & ~stop;

    assign busy        = (r_state != ST_IDLE);
    assign frame_done  = w_frame_end & (r_state == ST_PASS);
    assign frame_count = r_frame_count;

`ifdef VID_FRAME_CTRL_ERR_EN
    logic w_eol_early;
    logic w_eol_late;
    logic r_err_eol_early;
    logic r_err_eol_late;
    logic r_err_sof;

    vid_pos_counter #(
        .H_BEATS (H_BEATS),
        .V_LINES (V_LINES),
        .CNT_W   (CNT_W)
    ) u_pos (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_beat      (w_beat),
        .i_sof       (w_sof),
        .i_eol       (s_axis_video_tlast),
        .o_eol_early (w_eol_early),
        .o_eol_late  (w_eol_late),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_sof       <= 1'b0;
        end else if (w_start_acc) begin
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_sof       <= 1'b0;
        end else if (r_state == ST_PASS) begin
            if (w_eol_early) r_err_eol_early <= 1'b1;
            if (w_eol_late)  r_err_eol_late  <= 1'b1;
            if (w_sof)       r_err_sof       <= 1'b1;
        end
    end

    assign err_eol_early = r_err_eol_early;
    assign err_eol_late  = r_err_eol_late;
    assign err_sof       = r_err_sof;
`else
    vid_pos_counter #(
        .H_BEATS (H_BEATS),
        .V_LINES (V_LINES),
        .CNT_W   (CNT_W)
    ) u_pos (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_beat      (w_beat),
        .i_sof       (w_sof),
        .i_eol       (s_axis_video_tlast),
        .o_frame_end (w_frame_end)
    );

    assign err_eol_early = 1'b0;
    assign err_eol_late  = 1'b0;
    assign err_sof       = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_stop_pending <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stop_pending <= 1'b0;
                    if (w_start_acc) r_state <= ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (stop) begin
                        r_state        <= ST_IDLE;
                        r_stop_pending <= 1'b0;
                    end else if (w_sof) begin
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_frame_end) begin
                        r_frame_count <= r_frame_count + CNT_W'(1);
                        // A stop arriving on the final beat still ends capture here.
                        if (r_stop_pending || stop || oneshot) begin
                            r_state        <= ST_IDLE;
                            r_stop_pending <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT_SOF;
                        end
                    end else if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_stop_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_frame_ctrl.sv
// Directed bench for vid_frame_ctrl: gating, counting, stop/oneshot, errors, stalls, reset.
module tb_vid_frame_ctrl;

    localparam int H = 16;
    localparam int V = 64;
`ifdef VID_FRAME_CTRL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [95:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic [95:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tuser;
    logic        m_tlast;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        oneshot = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [11:0] frame_count;
    logic        err_eol_early;
    logic        err_eol_late;
    logic        err_sof;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int fd_cnt = 0;
    int seq_err = 0;
    logic capture_first = 1'b0;
    logic first_tuser = 1'b0;
    logic stall_en = 1'b0;
    logic [95:0] exp_q[$];
    int base_out;
    int base_fd;

    vid_frame_ctrl #(
        .H_BEATS (H),
        .V_LINES (V),
        .CNT_W   (12)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast),
        .start               (start),
        .stop                (stop),
        .oneshot             (oneshot),
        .busy                (busy),
        .frame_done          (frame_done),
        .frame_count         (frame_count),
        .err_eol_early       (err_eol_early),
        .err_eol_late        (err_eol_late),
        .err_sof             (err_sof)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: every downstream beat must match the next beat sent as "pass".
    always @(negedge aclk) begin
        logic [95:0] e;
        if (frame_done) fd_cnt++;
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (capture_first) begin
                first_tuser   = m_tuser;
                capture_first = 1'b0;
            end
            if (exp_q.size() == 0) begin
                seq_err++;
            end else begin
                e = exp_q.pop_front();
                if (m_tdata !== e) seq_err++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_range(input int f, input int ln, input int b_from, input int b_to,
                              input int last_at, input bit sof, input bit pass);
        bit hs;
        for (int b = b_from; b <= b_to; b++) begin
            s_tdata  = {32'(f), 32'(ln), 32'(b)};
            s_tuser  = sof && (b == b_from);
            s_tlast  = (b == last_at);
            s_tvalid = 1'b1;
            if (pass) exp_q.push_back(s_tdata);
            hs = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge aclk);
                if (s_tready) begin
                    hs = 1'b1;
                    break;
                end
            end
            if (!hs) chk("hs_timeout", 64'(hs), 64'(1));
            @(posedge aclk);
            #1;
            s_tvalid = 1'b0;
            s_tuser  = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic send_lines(input int f, input int l_from, input int l_to, input bit pass);
        for (int ln = l_from; ln <= l_to; ln++)
            send_range(f, ln, 0, H - 1, H - 1, ln == 0, pass);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge aclk);
        #1;
        stop = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge aclk);
        #1;
        s_tvalid = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_fcount", 64'(frame_count), 64'(0));
        chk("rst_fdone", 64'(frame_done), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        chk("rst_errs", 64'({err_eol_early, err_eol_late, err_sof}), 64'(0));
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        @(posedge aclk);
        #1;

        // Oneshot clean frame
        oneshot = 1'b1;
        pulse_start();
        chk("start_busy", 64'(busy), 64'(1));
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_lines(1, 0, V - 1, 1'b1);
        chk("os_beats", 64'(out_cnt - base_out), 64'(1024));
        chk("os_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("os_fcount", 64'(frame_count), 64'(1));
        chk("os_idle", 64'(busy), 64'(0));
        chk("os_seq", 64'(seq_err), 64'(0));

        // Input while idle, then start mid-frame: discard until next SOF
        base_out = out_cnt;
        send_lines(2, 0, 9, 1'b0);
        pulse_start();
        send_lines(2, 10, V - 1, 1'b0);
        chk("mid_discard", 64'(out_cnt - base_out), 64'(0));
        chk("mid_waiting", 64'(busy), 64'(1));
        capture_first = 1'b1;
        send_lines(3, 0, V - 1, 1'b1);
        chk("mid_first_tuser", 64'(first_tuser), 64'(1));
        chk("mid_beats", 64'(out_cnt - base_out), 64'(1024));
        chk("mid_fcount", 64'(frame_count), 64'(2));
        chk("mid_idle", 64'(busy), 64'(0));

        // Continuous mode, stop during line 10
        oneshot = 1'b0;
        pulse_start();
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_lines(4, 0, 9, 1'b1);
        send_range(4, 10, 0, 4, H - 1, 1'b0, 1'b1);
        pulse_stop();
        send_range(4, 10, 5, H - 1, H - 1, 1'b0, 1'b1);
        send_lines(4, 11, V - 1, 1'b1);
        chk("stop_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("stop_fcount", 64'(frame_count), 64'(3));
        chk("stop_idle", 64'(busy), 64'(0));
        chk("stop_beats", 64'(out_cnt - base_out), 64'(1024));
        base_out = out_cnt;
        send_lines(5, 0, V - 1, 1'b0);
        chk("stop_next_discard", 64'(out_cnt - base_out), 64'(0));
        chk("stop_next_fdone", 64'(fd_cnt - base_fd), 64'(1));

        // Early EOL on line 3 (tlast at beat 12)
        oneshot = 1'b1;
        pulse_start();
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_lines(6, 0, 2, 1'b1);
        send_range(6, 3, 0, 12, 12, 1'b0, 1'b1);
        chk("early_flag", 64'(err_eol_early), 64'(ERR_EN));
        chk("early_nolate", 64'(err_eol_late), 64'(0));
        send_lines(6, 4, V - 2, 1'b1);
        chk("early_no_done_yet", 64'(fd_cnt - base_fd), 64'(0));
        send_lines(6, V - 1, V - 1, 1'b1);
        chk("early_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("early_beats", 64'(out_cnt - base_out), 64'(1021));
        chk("early_fcount", 64'(frame_count), 64'(4));

        // Late EOL on line 5 (18 beats), then SOF restart on line 7
        pulse_start();
        chk("start_clears_err", 64'(err_eol_early), 64'(0));
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_lines(7, 0, 4, 1'b1);
        send_range(7, 5, 0, 17, 17, 1'b0, 1'b1);
        chk("late_flag", 64'(err_eol_late), 64'(ERR_EN));
        chk("late_noearly", 64'(err_eol_early), 64'(0));
        send_lines(7, 6, 6, 1'b1);
        send_range(7, 7, 0, H - 1, H - 1, 1'b1, 1'b1);
        chk("sof_flag", 64'(err_sof), 64'(ERR_EN));
        send_lines(7, 8, 69, 1'b1);
        chk("restart_no_done", 64'(fd_cnt - base_fd), 64'(0));
        send_lines(7, 70, 70, 1'b1);
        chk("restart_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("restart_beats", 64'(out_cnt - base_out), 64'(1138));
        chk("restart_fcount", 64'(frame_count), 64'(5));
        chk("restart_idle", 64'(busy), 64'(0));

        // Random downstream stalls
        stall_en = 1'b1;
        pulse_start();
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_lines(8, 0, V - 1, 1'b1);
        stall_en = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        chk("stall_seq", 64'(seq_err), 64'(0));
        chk("stall_beats", 64'(out_cnt - base_out), 64'(1024));
        chk("stall_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("stall_fcount", 64'(frame_count), 64'(6));
        chk("stall_q_empty", 64'(exp_q.size()), 64'(0));

        // Reset at line 20
        oneshot = 1'b0;
        pulse_start();
        send_lines(9, 0, 19, 1'b1);
        send_range(9, 20, 0, 7, H - 1, 1'b0, 1'b1);
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_fcount", 64'(frame_count), 64'(0));
        chk("mrst_fdone", 64'(frame_done), 64'(0));
        chk("mrst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("mrst_errs", 64'({err_eol_early, err_eol_late, err_sof}), 64'(0));
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        base_out = out_cnt;
        base_fd  = fd_cnt;
        send_range(9, 20, 8, H - 1, H - 1, 1'b0, 1'b0);
        send_lines(9, 21, V - 1, 1'b0);
        send_lines(10, 0, V - 1, 1'b0);
        chk("post_rst_discard", 64'(out_cnt - base_out), 64'(0));
        chk("post_rst_idle", 64'(busy), 64'(0));
        oneshot = 1'b1;
        pulse_start();
        send_lines(11, 0, V - 1, 1'b1);
        chk("post_rst_beats", 64'(out_cnt - base_out), 64'(1024));
        chk("post_rst_fdone", 64'(fd_cnt - base_fd), 64'(1));
        chk("post_rst_fcount", 64'(frame_count), 64'(1));
        chk("post_rst_seq", 64'(seq_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
